alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_core_n.sv | 45 ++++
 rtl/alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_NOT = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SLA = 4'b0111,
        OP_SRL = 4'b1000,
        OP_SRA = 4'b1001
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    localparam flags_t FLAGS_RST = '{c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1};

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SLA) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic flags_t mk_flags(input logic c, input logic v, input logic n, input logic z);
        return '{c: c, v: v, n: n, z: z};
    endfunction

endpackage

// File: rtl/alu_core_n.sv
// Combinational arithmetic/logic core: ADD, SUB, NOT, AND, OR, XOR with carry and overflow.
module alu_core_n
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]    i_a,
    input  logic [N-1:0]    i_b,
    input  logic [OP_W-1:0] i_op,
    output logic [N-1:0]    o_res_c,
    output logic            o_carry_c,
    output logic            o_ovf_c
);

    logic [N:0] w_sum;
    logic [N:0] w_diff;

    // One extra bit so the carry/borrow falls out of the top position
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res_c   = '0;
        o_carry_c = 1'b0;
        o_ovf_c   = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_res_c   = w_sum[N-1:0];
                o_carry_c = w_sum[N];
                o_ovf_c   = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                o_res_c   = w_diff[N-1:0];
                o_carry_c = ~w_diff[N];
                o_ovf_c   = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            OP_NOT: o_res_c = ~i_a;
            OP_AND: o_res_c = i_a & i_b;
            OP_OR:  o_res_c = i_a | i_b;
            OP_XOR: o_res_c = i_a ^ i_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, bit-serial shifts, held result registers.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned SHW = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    A,
    input  logic [N-1:0]    B,
    input  logic [OP_W-1:0] SELECT,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    OUT,
    output logic            FLAG_CARRY,
    output logic            FLAG_OVERFLOW,
    output logic            FLAG_NEGATIVE,
    output logic            FLAG_ZERO
);

    localparam logic [N-1:0] LP_N = N'(N);

    state_e          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_out;
    flags_t          r_flags;
    logic [SHW-1:0]  r_cnt;
    logic [N-1:0]    r_sh_val;
    logic [OP_W-1:0] r_sh_op;
    logic            r_sh_v;

    logic [N-1:0]    w_core_y;
    logic            w_core_c;
    logic            w_core_v;
    logic            w_is_shift;
    logic [SHW-1:0]  w_cnt;
    logic [N-1:0]    w_acc_y;
    logic            w_acc_c;
    logic            w_acc_v;
    logic [N-1:0]    w_step_y;
    logic            w_step_c;
    logic            w_step_v;

    alu_core_n #(.N(N)) u_core (
        .i_a       (A),
        .i_b       (B),
        .i_op      (SELECT),
        .o_res_c   (w_core_y),
        .o_carry_c (w_core_c),
        .o_ovf_c   (w_core_v)
    );

    // Shift distance saturates at the operand width
    assign w_is_shift = is_shift(SELECT);
    assign w_cnt      = (B > LP_N) ? SHW'(N) : SHW'(B);

    // Result written directly on accept: core ops, or a zero-distance shift passing A through
    always_comb begin
        w_acc_y = w_core_y;
        w_acc_c = w_core_c;
        w_acc_v = w_core_v;
        if (w_is_shift) begin
            w_acc_y = A;
            w_acc_c = 1'b0;
            w_acc_v = 1'b0;
        end
    end

    // One-bit shift step of the captured operand
    always_comb begin
        w_step_y = r_sh_val;
        w_step_c = 1'b0;
        case (r_sh_op)
            OP_SLL, OP_SLA: begin
                w_step_y = {r_sh_val[N-2:0], 1'b0};
                w_step_c = r_sh_val[N-1];
            end
            OP_SRL: begin
                w_step_y = {1'b0, r_sh_val[N-1:1]};
                w_step_c = r_sh_val[0];
            end
            OP_SRA: begin
                w_step_y = {r_sh_val[N-1], r_sh_val[N-1:1]};
                w_step_c = r_sh_val[0];
            end
            default: ;
        endcase
        w_step_v = (r_sh_op == OP_SLA) && (w_step_y[N-1] != r_sh_val[N-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_flags     <= FLAGS_RST;
            r_cnt       <= '0;
            r_sh_val    <= '0;
            r_sh_op     <= '0;
            r_sh_v      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_is_shift && (w_cnt != '0)) begin
                            r_sh_val <= A;
                            r_sh_op  <= SELECT;
                            r_sh_v   <= 1'b0;
                            r_cnt    <= w_cnt;
                            r_state  <= SHIFT;
                        end else begin
                            r_out       <= w_acc_y;
                            r_flags     <= mk_flags(w_acc_c, w_acc_v, w_acc_y[N-1], w_acc_y == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_sh_val <= w_step_y;
                    r_sh_v   <= r_sh_v | w_step_v;
                    r_cnt    <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_out       <= w_step_y;
                        r_flags     <= mk_flags(w_step_c, r_sh_v | w_step_v, w_step_y[N-1],
                                                w_step_y == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign OUT           = r_out;
    assign FLAG_CARRY    = r_flags.c;
    assign FLAG_OVERFLOW = r_flags.v;
    assign FLAG_NEGATIVE = r_flags.n;
    assign FLAG_ZERO     = r_flags.z;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: accepted operations queue model results, a monitor checks each delivered result.
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] A;
    logic [NW-1:0] B;
    logic [3:0]    SELECT;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] OUT;
    logic          FLAG_CARRY;
    logic          FLAG_OVERFLOW;
    logic          FLAG_NEGATIVE;
    logic          FLAG_ZERO;

    typedef struct {
        int y;
        int flags;
        int lat;
        int acc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_acc = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rand_ready = 0;
    bit   force_ready = 1;

    alu_pipe #(.N(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .SELECT        (SELECT),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .OUT           (OUT),
        .FLAG_CARRY    (FLAG_CARRY),
        .FLAG_OVERFLOW (FLAG_OVERFLOW),
        .FLAG_NEGATIVE (FLAG_NEGATIVE),
        .FLAG_ZERO     (FLAG_ZERO)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endfunction

    // Reference: plain integer arithmetic on the opcode rules; flags packed as c*8+v*4+n*2+z
    function automatic exp_t model(input int a, input int b, input int sel);
        exp_t e;
        int mask = (1 << NW) - 1;
        int half = 1 << (NW - 1);
        int sa = (a >= half) ? a - (1 << NW) : a;
        int sb = (b >= half) ? b - (1 << NW) : b;
        int cnt = (b > NW) ? NW : b;
        int r = 0;
        int c = 0;
        int v = 0;
        int s0;
        e.lat = 1;
        e.acc = 0;
        case (sel)
            0: begin r = a + b; c = (r > mask); v = ((sa + sb) < -half) || ((sa + sb) >= half); end
            1: begin r = a - b; c = (a >= b);   v = ((sa - sb) < -half) || ((sa - sb) >= half); end
            2: r = ~a;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6, 7: begin
                r = a << cnt;
                c = (cnt > 0) ? ((a >> (NW - cnt)) & 1) : 0;
                if (sel == 7) begin
                    s0 = (a >> (NW - 1)) & 1;
                    for (int k = 1; k <= cnt; k++)
                        if ((((a << k) >> (NW - 1)) & 1) != s0) v = 1;
                end
                e.lat = cnt + 1;
            end
            8: begin r = a >> cnt;  c = (cnt > 0) ? ((a >> (cnt - 1)) & 1) : 0; e.lat = cnt + 1; end
            9: begin r = sa >>> cnt; c = (cnt > 0) ? ((a >> (cnt - 1)) & 1) : 0; e.lat = cnt + 1; end
            default: r = 0;
        endcase
        r = r & mask;
        e.y = r;
        e.flags = c * 8 + v * 4 + ((r >> (NW - 1)) & 1) * 2 + ((r == 0) ? 1 : 0);
        return e;
    endfunction

    // Accept observer: push expectation on every handshake edge
    always @(posedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e = model(int'(A), int'(B), int'(SELECT));
            e.acc = cyc;
            q.push_back(e);
            n_acc++;
        end
        cyc++;
    end

    // Consumer ready driver
    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = force_ready;
    end

    // Result monitor
    always @(negedge clk) begin
        exp_t e;
        int   fl;
        if (rst) begin
            q.delete();
            seen = 0;
        end else if (!out_valid) begin
            seen = 0;
        end else if (!seen) begin
            seen = 1;
            fl = int'({FLAG_CARRY, FLAG_OVERFLOW, FLAG_NEGATIVE, FLAG_ZERO});
            check("in_ready_while_valid", int'(in_ready), 0);
            if (q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = q.pop_front();
                check("out", int'(OUT), e.y);
                check("flags_cvnz", fl, e.flags);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input int a, input int b, input int sel, output int edges);
        int n0;
        n0 = n_acc;
        A = NW'(a);
        B = NW'(b);
        SELECT = 4'(sel);
        in_valid = 1'b1;
        edges = 0;
        while (n_acc == n0 && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        if (n_acc == n0) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || !in_ready) check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out"},       int'(OUT), 0);
        check({tag, "_flags"},     int'({FLAG_CARRY, FLAG_OVERFLOW, FLAG_NEGATIVE, FLAG_ZERO}), 1);
    endtask

    initial begin
        int   ed;
        int   a;
        int   b;
        int   sel;
        int   nacc0;
        exp_t hold;

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        SELECT = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Directed vectors; first accept must land on the first edge after reset release
        issue(4'b1110, 4'b0010, 0, ed);
        check("first_accept_edges", ed, 1);
        issue(4'b0110, 4'b0100, 1, ed);
        issue(4'b0010, 4'b0101, 1, ed);
        issue(4'b1110, 4'b0010, 9, ed);
        issue(4'b0110, 4'b0100, 7, ed);
        issue(4'b0101, 4'b1001, 6, ed);
        issue(4'b0101, 4'b0001, 15, ed);
        issue(4'b1011, 4'b0000, 8, ed);
        issue(4'b0111, 4'b0001, 0, ed);
        drain();

        // Backpressure: result held while new operands are presented
        force_ready = 0;
        @(negedge clk);
        @(negedge clk);
        issue(4'b0011, 4'b0100, 0, ed);
        hold = model(4'b0011, 4'b0100, 0);
        nacc0 = n_acc;
        A = 4'b0001;
        B = 4'b0001;
        SELECT = 4'b0001;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready",  int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out",       int'(OUT), hold.y);
            check("bp_flags",     int'({FLAG_CARRY, FLAG_OVERFLOW, FLAG_NEGATIVE, FLAG_ZERO}), hold.flags);
        end
        in_valid = 1'b0;
        force_ready = 1;
        drain();
        check("bp_no_accept", n_acc - nacc0, 0);

        // Reset during a shift discards the operation immediately
        issue(4'b1000, 4'b0011, 8, ed);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("midshift_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(4'b0011, 4'b0010, 0, ed);
        check("post_rst_accept_edges", ed, 1);
        drain();

        // Randomized traffic with random consumer stalls
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
            sel = int'($urandom_range(0, 15));
            issue(a, b, sel, ed);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        drain();
        check("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
